// File: rtl/mdu_ctrl.sv
// Sequencer between the RV32IM EX stage and the multi-cycle MDU: latch, issue, stall, write back, drain on flush.
// Optional MDU_DIV_SHORTCUT_EN: divide-by-zero and signed-overflow div/rem retire from IDLE without using the MDU.
module mdu_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [2:0]      ex_op,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_rs2,
    input  logic [4:0]      ex_rd,
    input  logic            flush,
    output logic            stall,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            mdu_valid,
    output logic [2:0]      mdu_op,
    output logic [XLEN-1:0] mdu_rs1,
    output logic [XLEN-1:0] mdu_rs2,
    input  logic [XLEN-1:0] mdu_result,
    input  logic            mdu_ready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    logic            r_mdu_valid;
    logic            r_wb_pend;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_rs1;
    logic [XLEN-1:0] r_rs2;
    logic [4:0]      r_rd;
    logic [4:0]      r_wb_rd;
    logic [XLEN-1:0] r_wb_data;
    logic            w_stall;
    logic            w_wb_valid;

`ifdef MDU_DIV_SHORTCUT_EN
    localparam logic [XLEN-1:0] L_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] L_ONES = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] L_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    // Div/rem cases whose architectural result is fixed and needs no MDU cycles.
    function automatic logic div_special(input logic [2:0] op,
                                         input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b);
        logic by_zero;
        logic ovf;
        by_zero = op[2] && (b == L_ZERO);
        ovf     = op[2] && !op[0] && (a == L_MIN) && (b == L_ONES);
        return by_zero || ovf;
    endfunction

    function automatic logic [XLEN-1:0] div_special_result(input logic [2:0] op,
                                                           input logic [XLEN-1:0] a,
                                                           input logic [XLEN-1:0] b);
        logic [XLEN-1:0] res;
        if (b == L_ZERO) begin
            res = op[1] ? a : L_ONES;
        end else begin
            res = op[1] ? L_ZERO : L_MIN;
        end
        return res;
    endfunction

    logic            w_shortcut;
    logic [XLEN-1:0] w_shortcut_data;

    // Classify the EX operands for the fixed-result path.
    always_comb begin
        w_shortcut      = div_special(ex_op, ex_rs1, ex_rs2);
        w_shortcut_data = div_special_result(ex_op, ex_rs1, ex_rs2);
    end
`endif

    // Sequencer state, latched operands and registered MDU/writeback outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mdu_valid <= 1'b0;
            r_wb_pend   <= 1'b0;
            r_op        <= 3'd0;
            r_rs1       <= {XLEN{1'b0}};
            r_rs2       <= {XLEN{1'b0}};
            r_rd        <= 5'd0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= {XLEN{1'b0}};
        end else begin
            r_mdu_valid <= 1'b0;
            r_wb_pend   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ex_valid && !flush) begin
                        r_op  <= ex_op;
                        r_rs1 <= ex_rs1;
                        r_rs2 <= ex_rs2;
                        r_rd  <= ex_rd;
`ifdef MDU_DIV_SHORTCUT_EN
                        if (w_shortcut) begin
                            r_wb_data <= w_shortcut_data;
                            r_wb_rd   <= ex_rd;
                            r_wb_pend <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_mdu_valid <= 1'b1;
                            r_state     <= S_ISSUE;
                        end
`else
                        r_mdu_valid <= 1'b1;
                        r_state     <= S_ISSUE;
`endif
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                // A ready seen alongside the start pulse is not a completion.
                S_ISSUE: begin
                    r_state <= flush ? S_DRAIN : S_WAIT;
                end
                S_WAIT: begin
                    if (flush) begin
                        r_state <= mdu_ready ? S_IDLE : S_DRAIN;
                    end else if (mdu_ready) begin
                        r_wb_data <= mdu_result;
                        r_wb_rd   <= r_rd;
                        r_wb_pend <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_DRAIN: begin
                    r_state <= mdu_ready ? S_IDLE : S_DRAIN;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Front-end hold; DRAIN only stalls when a new instruction is waiting behind it.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE:  w_stall = ex_valid && !flush;
            S_ISSUE: w_stall = 1'b1;
            S_WAIT:  w_stall = 1'b1;
            S_DRAIN: w_stall = ex_valid;
            S_DONE:  w_stall = 1'b0;
            default: w_stall = 1'b0;
        endcase
    end

    // A flush landing on the writeback cycle kills the strobe.
    always_comb begin
        if (flush) begin
            w_wb_valid = 1'b0;
        end else begin
            w_wb_valid = r_wb_pend;
        end
    end

    assign stall     = w_stall;
    assign wb_valid  = w_wb_valid;
    assign wb_rd     = r_wb_rd;
    assign wb_data   = r_wb_data;
    assign mdu_valid = r_mdu_valid;
    assign mdu_op    = r_op;
    assign mdu_rs1   = r_rs1;
    assign mdu_rs2   = r_rs2;

endmodule
